// File: rtl/uart_alu_if.sv
// Frame assembler between UART rx/tx and a combinational ALU: collects A, B and opcode bytes,
// then launches the ALU result into the transmitter. Optional inter-byte timeout: IF_TIMEOUT_EN.
module uart_alu_if #(
    parameter int unsigned NB_DATA        = 8,
    parameter int unsigned NB_OP          = 6,
    parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_rx_done_tick,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_tx_done_tick,
    input  logic [NB_DATA-1:0] i_alu_result,
    output logic [NB_DATA-1:0] o_data_a,
    output logic [NB_DATA-1:0] o_data_b,
    output logic [NB_OP-1:0]   o_op,
    output logic               o_tx_start,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_busy,
    output logic               o_timeout
);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    typedef enum logic [2:0] {
        StA,
        StB,
        StOp,
        StExec,
        StSend,
        StWaitTx
    } state_e;

    state_e             state_q, state_d;
    logic [NB_DATA-1:0] data_a_q, data_a_d;
    logic [NB_DATA-1:0] data_b_q, data_b_d;
    logic [NB_OP-1:0]   op_q, op_d;
    logic [NB_DATA-1:0] tx_data_q, tx_data_d;
    logic               tx_start_q, tx_start_d;
    logic               busy_q, busy_d;

`ifdef IF_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            timeout_q, timeout_d;
`endif

    always_comb begin
        state_d    = state_q;
        data_a_d   = data_a_q;
        data_b_d   = data_b_q;
        op_d       = op_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;

        case (state_q)
            StA: begin
                if (i_rx_done_tick) begin
                    data_a_d = i_rx_data;
                    state_d  = StB;
                end
            end
            StB: begin
                if (i_rx_done_tick) begin
                    data_b_d = i_rx_data;
                    state_d  = StOp;
                end
            end
            StOp: begin
                if (i_rx_done_tick) begin
                    op_d    = i_rx_data[NB_OP-1:0];
                    state_d = StExec;
                end
            end
            // ALU inputs changed on the previous edge; give it a full cycle to settle.
            StExec: state_d = StSend;
            StSend: begin
                tx_data_d  = i_alu_result;
                tx_start_d = 1'b1;
                state_d    = StWaitTx;
            end
            StWaitTx: begin
                if (i_tx_done_tick) begin
                    state_d = StA;
                end
            end
            default: state_d = StA;
        endcase

`ifdef IF_TIMEOUT_EN
        timeout_d = 1'b0;
        cnt_d     = '0;
        // A tick on the expiry cycle wins: it is handled above and the counter simply clears.
        if ((state_q == StB || state_q == StOp) && !i_rx_done_tick) begin
            if (cnt_q == CntMax) begin
                state_d   = StA;
                timeout_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
`endif

        busy_d = (state_d == StExec) || (state_d == StSend) || (state_d == StWaitTx);
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= StA;
            data_a_q   <= '0;
            data_b_q   <= '0;
            op_q       <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_a_q   <= data_a_d;
            data_b_q   <= data_b_d;
            op_q       <= op_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
        end
    end

`ifdef IF_TIMEOUT_EN
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_timeout = timeout_q;
`else
    assign o_timeout = 1'b0;
`endif

    assign o_data_a   = data_a_q;
    assign o_data_b   = data_b_q;
    assign o_op       = op_q;
    assign o_tx_data  = tx_data_q;
    assign o_tx_start = tx_start_q;
    assign o_busy     = busy_q;

endmodule

// File: tb/tb_uart_alu_if.sv
// Bench for uart_alu_if: directed frames plus random traffic checked every cycle against a
// transaction-level model (byte count, launch countdown, transmit-in-flight flag).
module tb_uart_alu_if;

    localparam int TO = 100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_tick = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       tx_done = 1'b0;
    logic [7:0] alu_result;
    logic [7:0] o_data_a, o_data_b, o_tx_data;
    logic [5:0] o_op;
    logic       o_tx_start, o_busy, o_timeout;

    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] alu(input logic [7:0] a, input logic [7:0] b,
                                       input logic [5:0] op);
        case (op)
            6'h20:   alu = a + b;
            6'h22:   alu = a - b;
            6'h24:   alu = a & b;
            default: alu = a ^ b;
        endcase
    endfunction

    assign alu_result = alu(o_data_a, o_data_b, o_op);

    uart_alu_if #(
        .NB_DATA       (8),
        .NB_OP         (6),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .i_clk         (clk),
        .i_reset       (rst_n),
        .i_rx_done_tick(rx_tick),
        .i_rx_data     (rx_data),
        .i_tx_done_tick(tx_done),
        .i_alu_result  (alu_result),
        .o_data_a      (o_data_a),
        .o_data_b      (o_data_b),
        .o_op          (o_op),
        .o_tx_start    (o_tx_start),
        .o_tx_data     (o_tx_data),
        .o_busy        (o_busy),
        .o_timeout     (o_timeout)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frame progress as a byte count, then a launch countdown, then tx in flight.
    logic [7:0] m_a, m_b, m_tx;
    logic [5:0] m_op;
    logic       m_start, m_to, m_txing;
    int         m_nbytes, m_launch, m_idle;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_a <= 0; m_b <= 0; m_op <= 0; m_tx <= 0;
            m_start <= 0; m_to <= 0; m_txing <= 0;
            m_nbytes <= 0; m_launch <= 0; m_idle <= 0;
        end else begin
            m_start <= 0;
            m_to    <= 0;
            if (m_launch == 2) begin
                m_launch <= 1;
            end else if (m_launch == 1) begin
                m_launch <= 0;
                m_txing  <= 1;
                m_start  <= 1;
                m_tx     <= alu(m_a, m_b, m_op);
            end else if (m_txing) begin
                if (tx_done) m_txing <= 0;
            end else if (rx_tick) begin
                m_idle <= 0;
                if (m_nbytes == 0) begin
                    m_a <= rx_data; m_nbytes <= 1;
                end else if (m_nbytes == 1) begin
                    m_b <= rx_data; m_nbytes <= 2;
                end else begin
                    m_op <= rx_data[5:0]; m_nbytes <= 0; m_launch <= 2;
                end
            end else if (m_nbytes != 0) begin
`ifdef IF_TIMEOUT_EN
                if (m_idle == TO - 1) begin
                    m_to <= 1; m_nbytes <= 0; m_idle <= 0;
                end else begin
                    m_idle <= m_idle + 1;
                end
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("data_a", o_data_a, m_a);
            chk("data_b", o_data_b, m_b);
            chk("op", {2'b00, o_op}, {2'b00, m_op});
            chk("tx_data", o_tx_data, m_tx);
            chk("tx_start", {7'd0, o_tx_start}, {7'd0, m_start});
            chk("busy", {7'd0, o_busy}, {7'd0, ((m_launch > 0) || m_txing)});
            chk("timeout", {7'd0, o_timeout}, {7'd0, m_to});
        end
    end

    // Drive one cycle of inputs; returns just after the edge that consumed them.
    task automatic step(input logic rx, input logic [7:0] d, input logic txd);
        rx_tick = rx;
        rx_data = d;
        tx_done = txd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_data_a", o_data_a, 8'h00);
        chk("rst_busy", {7'd0, o_busy}, 8'h00);
        chk("rst_tx_start", {7'd0, o_tx_start}, 8'h00);
        rst_n = 1'b1;

        // Basic frame 5 + 3.
        step(1, 8'h05, 0);
        step(1, 8'h03, 0);
        step(1, 8'h20, 0);
        chk("f1_a", o_data_a, 8'h05);
        chk("f1_b", o_data_b, 8'h03);
        chk("f1_op", {2'b00, o_op}, 8'h20);
        chk("f1_busy", {7'd0, o_busy}, 8'h01);
        step(0, 8'h00, 0);
        chk("f1_no_start_early", {7'd0, o_tx_start}, 8'h00);
        step(0, 8'h00, 0);
        chk("f1_start", {7'd0, o_tx_start}, 8'h01);
        chk("f1_tx_data", o_tx_data, 8'h08);
        step(1, 8'hAA, 0);
        chk("f1_start_once", {7'd0, o_tx_start}, 8'h00);
        chk("f1_drop_a", o_data_a, 8'h05);
        chk("f1_busy_wait", {7'd0, o_busy}, 8'h01);
        step(0, 8'h00, 1);
        chk("f1_idle", {7'd0, o_busy}, 8'h00);

        // Fresh frame after the dropped byte.
        step(1, 8'h01, 0);
        chk("f2_a", o_data_a, 8'h01);
        step(1, 8'h02, 0);
        step(1, 8'h20, 0);
        step(0, 8'h00, 0);
        step(0, 8'h00, 0);
        chk("f2_tx_data", o_tx_data, 8'h03);
        step(0, 8'h00, 1);

        // Asynchronous reset while waiting for the opcode.
        step(1, 8'h11, 0);
        step(1, 8'h22, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_a", o_data_a, 8'h00);
        chk("async_b", o_data_b, 8'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1, 8'h33, 0);
        chk("after_rst_a", o_data_a, 8'h33);
        chk("after_rst_b", o_data_b, 8'h00);
        step(1, 8'h04, 0);
        step(1, 8'hE2, 0);
        chk("op_mask", {2'b00, o_op}, 8'h22);
        step(0, 8'h00, 0);
        step(0, 8'h00, 0);
        chk("sub_tx_data", o_tx_data, 8'h2F);
        step(0, 8'h00, 1);

`ifdef IF_TIMEOUT_EN
        step(1, 8'h44, 0);
        repeat (TO - 1) step(0, 8'h00, 0);
        chk("to_not_yet", {7'd0, o_timeout}, 8'h00);
        step(0, 8'h00, 0);
        chk("to_pulse", {7'd0, o_timeout}, 8'h01);
        step(0, 8'h00, 0);
        chk("to_one_cycle", {7'd0, o_timeout}, 8'h00);
        chk("to_keeps_a", o_data_a, 8'h44);
        step(1, 8'h01, 0);
        step(1, 8'h09, 0);
        step(1, 8'h20, 0);
        chk("to_next_a", o_data_a, 8'h01);
        chk("to_next_b", o_data_b, 8'h09);
        step(0, 8'h00, 0);
        step(0, 8'h00, 0);
        chk("to_next_tx", o_tx_data, 8'h0A);
        step(0, 8'h00, 1);

        step(1, 8'h50, 0);
        repeat (TO - 1) step(0, 8'h00, 0);
        step(1, 8'h60, 0);
        chk("expiry_tick_no_to", {7'd0, o_timeout}, 8'h00);
        chk("expiry_tick_b", o_data_b, 8'h60);
        step(1, 8'h20, 0);
        chk("expiry_tick_busy", {7'd0, o_busy}, 8'h01);
        step(0, 8'h00, 0);
        step(0, 8'h00, 0);
        step(0, 8'h00, 1);
`else
        step(1, 8'h44, 0);
        repeat (150) step(0, 8'h00, 0);
        chk("no_to", {7'd0, o_timeout}, 8'h00);
        step(1, 8'h09, 0);
        chk("wait_forever_b", o_data_b, 8'h09);
        chk("wait_forever_a", o_data_a, 8'h44);
        step(1, 8'h20, 0);
        step(0, 8'h00, 0);
        step(0, 8'h00, 0);
        step(0, 8'h00, 1);
`endif

        // Random traffic, including ticks in every state and stray tx_done pulses.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) < 30) ? 1'b1 : 1'b0, 8'($urandom),
                 ($urandom_range(0, 99) < 15) ? 1'b1 : 1'b0);
        end
        step(0, 8'h00, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
